// File: rtl/cmd_proc_seq.sv
// -----------------------------------------------------------------------------
// cmd_proc_seq
//
// Command sequencer for the line-following robot.  A packed command word from
// the UART wrapper is captured into a shift register and consumed two bits at
// a time, one command per line loss (LSB pair first).  For every command the
// block drives `go` and a signed open-loop steering override `err_opn_lp`
// toward the PID/motor path.  Debounced bumpers pause motion in a collision
// state, during which the piezo is pulsed.
//
// Optional feature macro: CMD_PROC_BUZZ_EN
//   defined   : buzz goes high on collision entry and toggles every BUZZ_CYC.
//   undefined : buzz is tied low; collision behaviour is otherwise identical.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   cmd           in   [CMD_W-1:0] packed command word (2 bits per command)
//   cmd_rdy       in   level, `cmd` valid
//   clr_cmd_rdy   out  one-cycle pulse in the cycle `cmd` is captured
//   line_present  in   IR line detect
//   BMPL_n        in   left bumper, active-low, already synchronised
//   BMPR_n        in   right bumper, active-low, already synchronised
//   go            out  enable forward ramp (low clears PID I-term)
//   err_opn_lp    out  [ERR_W-1:0] signed steering override, +ve steers right
//   buzz          out  piezo drive
//   busy          out  high in every state except IDLE
//   collision     out  high while in the collision state
//
// Command encoding: 00 end, 01 veer right, 10 veer left,
//                   11 turn toward the side of the last veer.
// -----------------------------------------------------------------------------
module cmd_proc_seq #(
  parameter int                CMD_W     = 16,
  parameter int                ERR_W     = 12,
  parameter logic [ERR_W-1:0]  VEER_MAG  = 12'h340,
  parameter logic [ERR_W-1:0]  TURN1_MAG = 12'h1E0,
  parameter logic [ERR_W-1:0]  TURN2_MAG = 12'h380,
  parameter logic [25:0]       TURN1_CYC = 26'd46_150_000,
  parameter logic [25:0]       STOP_CYC  = 26'd1_000_000,
  parameter logic [25:0]       TURN2_CYC = 26'd65_000_000,
  parameter logic [25:0]       BUZZ_CYC  = 26'd5_000_000,
  parameter logic [19:0]       DB_CYC    = 20'd500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CMD_W-1:0]        cmd,
  input  logic                    cmd_rdy,
  output logic                    clr_cmd_rdy,
  input  logic                    line_present,
  input  logic                    BMPL_n,
  input  logic                    BMPR_n,
  output logic                    go,
  output logic signed [ERR_W-1:0] err_opn_lp,
  output logic                    buzz,
  output logic                    busy,
  output logic                    collision
);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    VEER,
    TURN1,
    TSTOP,
    TURN2,
    COLL
  } state_t;

  // Timer increments and sticks at all-ones rather than wrapping, so a very
  // long phase can never look like a freshly cleared one.
  function automatic logic [25:0] sat_inc(input logic [25:0] t);
    return (&t) ? t : t + 26'd1;
  endfunction

  // Steering magnitude with direction applied; positive steers right.
  function automatic logic signed [ERR_W-1:0] steer(input logic [ERR_W-1:0] mag,
                                                    input logic             rght);
    logic signed [ERR_W-1:0] m;
    m = $signed(mag);
    return rght ? m : -m;
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic [CMD_W-1:0]        cmd_sr;
  logic [CMD_W-1:0]        sr_nxt;
  logic [CMD_W-1:0]        sr_shift;
  logic [25:0]             timer;
  logic [25:0]             timer_nxt;
  logic                    last_rght;
  logic                    last_rght_nxt;
  logic                    ack_nxt;
  logic                    go_nxt;
  logic signed [ERR_W-1:0] err_nxt;
  logic                    bump;
  logic [19:0]             db_cnt;

  assign sr_shift = {2'b00, cmd_sr[CMD_W-1:2]};

  // ---------------------------------------------------------------------------
  // Bumper debounce: `bump` flips only after the opposite condition has held
  // for DB_CYC consecutive samples; any bounce restarts the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      bump   <= 1'b0;
    end else begin
      if (bump ? (BMPL_n && BMPR_n) : (!BMPL_n || !BMPR_n)) begin
        if (db_cnt >= DB_CYC - 20'd1) begin
          bump   <= ~bump;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 20'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output decode.  Outputs are registered from these
  // next values so every output moves on the same edge as the state.
  // ---------------------------------------------------------------------------
`ifdef CMD_PROC_BUZZ_EN
  logic buzz_nxt;
`endif

  always_comb begin
    state_nxt     = state;
    sr_nxt        = cmd_sr;
    timer_nxt     = sat_inc(timer);
    last_rght_nxt = last_rght;
    ack_nxt       = 1'b0;

    // A debounced bump outranks any line or timer event while moving.
    if (state != IDLE && bump) begin
      state_nxt = COLL;
      if (state != COLL) timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_rdy && line_present) begin
            sr_nxt    = cmd;
            ack_nxt   = 1'b1;
            state_nxt = MOVE;
          end
        end
        MOVE: begin
          if (!line_present) begin
            case (cmd_sr[1:0])
              2'b00: state_nxt = IDLE;
              2'b01, 2'b10: begin
                state_nxt     = VEER;
                last_rght_nxt = (cmd_sr[1:0] == 2'b01);
              end
              default: begin
                state_nxt = TURN1;
                timer_nxt = '0;
              end
            endcase
          end
        end
        VEER: begin
          if (line_present) begin
            sr_nxt    = sr_shift;
            state_nxt = MOVE;
          end
        end
        TURN1: begin
          if (timer >= TURN1_CYC - 26'd1) begin
            state_nxt = TSTOP;
            timer_nxt = '0;
          end
        end
        TSTOP: begin
          if (timer >= STOP_CYC - 26'd1) begin
            state_nxt = TURN2;
            timer_nxt = '0;
          end
        end
        TURN2: begin
          // Line returns before the minimum phase-2 time are still the line
          // we just left, so they are ignored.
          if (timer >= TURN2_CYC && line_present) begin
            sr_nxt    = sr_shift;
            state_nxt = MOVE;
          end
        end
        COLL: begin
          // Command register untouched: the interrupted command is decoded
          // again from MOVE.
          state_nxt = MOVE;
        end
        default: state_nxt = IDLE;
      endcase
    end

`ifdef CMD_PROC_BUZZ_EN
    buzz_nxt = 1'b0;
    if (state_nxt == COLL) begin
      if (state != COLL) begin
        buzz_nxt = 1'b1;
      end else if (timer >= BUZZ_CYC - 26'd1) begin
        buzz_nxt  = ~buzz;
        timer_nxt = '0;
      end else begin
        buzz_nxt = buzz;
      end
    end
`endif

    go_nxt  = 1'b0;
    err_nxt = '0;
    case (state_nxt)
      MOVE:  go_nxt = 1'b1;
      VEER: begin
        go_nxt  = 1'b1;
        err_nxt = steer(VEER_MAG, last_rght_nxt);
      end
      TURN1: begin
        // go held low on the first cycle of the turn to clear the I-term.
        go_nxt  = (timer_nxt != 26'd0);
        err_nxt = steer(TURN1_MAG, last_rght_nxt);
      end
      TURN2: begin
        go_nxt  = 1'b1;
        err_nxt = steer(TURN2_MAG, last_rght_nxt);
      end
      default: begin
        go_nxt  = 1'b0;
        err_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_sr      <= '0;
      timer       <= '0;
      last_rght   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      go          <= 1'b0;
      err_opn_lp  <= '0;
      busy        <= 1'b0;
      collision   <= 1'b0;
`ifdef CMD_PROC_BUZZ_EN
      buzz        <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cmd_sr      <= sr_nxt;
      timer       <= timer_nxt;
      last_rght   <= last_rght_nxt;
      clr_cmd_rdy <= ack_nxt;
      go          <= go_nxt;
      err_opn_lp  <= err_nxt;
      busy        <= (state_nxt != IDLE);
      collision   <= (state_nxt == COLL);
`ifdef CMD_PROC_BUZZ_EN
      buzz        <= buzz_nxt;
`endif
    end
  end

`ifndef CMD_PROC_BUZZ_EN
  // Piezo disabled: output tied low; the half-period parameter is kept
  // referenced so the parameter list stays identical across builds.
  assign buzz = 1'b0;
  logic buzz_cyc_unused;
  assign buzz_cyc_unused = |BUZZ_CYC;
`endif

endmodule

// File: tb/tb_cmd_proc_seq.sv
module tb_cmd_proc_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        line_present;
  logic        BMPL_n;
  logic        BMPR_n;
  logic        go;
  logic [11:0] err_opn_lp;
  logic        buzz;
  logic        busy;
  logic        collision;

  int n_cmp;
  int n_bad;

`ifdef CMD_PROC_BUZZ_EN
  localparam logic BZ = 1'b1;
`else
  localparam logic BZ = 1'b0;
`endif

  cmd_proc_seq #(
    .CMD_W     (16),
    .ERR_W     (12),
    .VEER_MAG  (12'h340),
    .TURN1_MAG (12'h1E0),
    .TURN2_MAG (12'h380),
    .TURN1_CYC (26'd10),
    .STOP_CYC  (26'd3),
    .TURN2_CYC (26'd8),
    .BUZZ_CYC  (26'd4),
    .DB_CYC    (20'd2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .line_present (line_present),
    .BMPL_n       (BMPL_n),
    .BMPR_n       (BMPR_n),
    .go           (go),
    .err_opn_lp   (err_opn_lp),
    .buzz         (buzz),
    .busy         (busy),
    .collision    (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cmd = '0;
    cmd_rdy = 1'b0;
    line_present = 1'b1;
    BMPL_n = 1'b1;
    BMPR_n = 1'b1;
    repeat (2) tick();
    check_val("rst_go", go, 0);
    check_val("rst_err", err_opn_lp, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_clr", clr_cmd_rdy, 0);
    check_val("rst_buzz", buzz, 0);
    check_val("rst_coll", collision, 0);
    #2 rst_n = 1'b1;

    // capture
    cmd = 16'h0001; cmd_rdy = 1'b1;
    tick();
    check_val("cap_clr", clr_cmd_rdy, 1);
    check_val("cap_busy", busy, 1);
    check_val("cap_go", go, 1);
    check_val("cap_err", err_opn_lp, 0);
    cmd_rdy = 1'b0;
    tick();
    check_val("cap_clr_pulse", clr_cmd_rdy, 0);
    check_val("cap_go2", go, 1);

    // veer right then stop
    line_present = 1'b0; tick();
    check_val("veer_err", err_opn_lp, 12'h340);
    check_val("veer_go", go, 1);
    line_present = 1'b1; tick();
    check_val("veer_back_err", err_opn_lp, 0);
    check_val("veer_back_busy", busy, 1);
    line_present = 1'b0; tick();
    check_val("stop_go", go, 0);
    check_val("stop_busy", busy, 0);
    line_present = 1'b1;

    // left veer then turn
    cmd = 16'h000E; cmd_rdy = 1'b1; tick();
    check_val("turn_cap_clr", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    line_present = 1'b0; tick();
    check_val("lveer_err", err_opn_lp, 12'hCC0);
    line_present = 1'b1; tick();
    check_val("lveer_back_go", go, 1);
    line_present = 1'b0; tick();
    check_val("t1_first_go", go, 0);
    check_val("t1_first_err", err_opn_lp, 12'hE20);
    for (int i = 1; i < 10; i++) begin
      tick();
      check_val("t1_go", go, 1);
      check_val("t1_err", err_opn_lp, 12'hE20);
    end
    tick();
    check_val("tstop_go_a", go, 0);
    check_val("tstop_err", err_opn_lp, 0);
    tick(); tick();
    check_val("tstop_go_c", go, 0);
    check_val("tstop_busy", busy, 1);
    tick();
    check_val("t2_go", go, 1);
    check_val("t2_err", err_opn_lp, 12'hC80);
    repeat (5) tick();
    check_val("t2_err_t5", err_opn_lp, 12'hC80);
    line_present = 1'b1; tick();
    check_val("t2_early_line6", err_opn_lp, 12'hC80);
    tick();
    check_val("t2_early_line7", err_opn_lp, 12'hC80);
    tick();
    check_val("t2_early_line8", err_opn_lp, 12'hC80);
    tick();
    check_val("t2_exit_err", err_opn_lp, 0);
    check_val("t2_exit_go", go, 1);
    line_present = 1'b0; tick();
    check_val("turn_end_busy", busy, 0);
    line_present = 1'b1;

    // collision
    cmd = 16'h0001; cmd_rdy = 1'b1; tick();
    cmd_rdy = 1'b0;
    BMPL_n = 1'b0; tick();
    BMPL_n = 1'b1; tick(); tick();
    check_val("glitch_coll", collision, 0);
    check_val("glitch_go", go, 1);
    BMPL_n = 1'b0; tick(); tick();
    check_val("db_coll_pre", collision, 0);
    tick();
    check_val("coll_coll", collision, 1);
    check_val("coll_go", go, 0);
    check_val("coll_err", err_opn_lp, 0);
    check_val("coll_busy", busy, 1);
    check_val("coll_buzz0", buzz, BZ);
    repeat (3) tick();
    check_val("coll_buzz3", buzz, BZ);
    tick();
    check_val("coll_buzz4", buzz, 0);
    repeat (3) tick();
    check_val("coll_buzz7", buzz, 0);
    tick();
    check_val("coll_buzz8", buzz, BZ);
    BMPL_n = 1'b1; tick(); tick();
    check_val("coll_hold", collision, 1);
    tick();
    check_val("coll_exit", collision, 0);
    check_val("coll_exit_go", go, 1);
    check_val("coll_exit_buzz", buzz, 0);
    line_present = 1'b0; tick();
    check_val("coll_redo_veer", err_opn_lp, 12'h340);
    line_present = 1'b1; tick();
    line_present = 1'b0; tick();
    check_val("coll_end_busy", busy, 0);
    line_present = 1'b1;

    // full word with a pending command held during the run
    cmd = 16'h5555; cmd_rdy = 1'b1; tick();
    check_val("full_cap_clr", clr_cmd_rdy, 1);
    cmd = 16'h0002;
    for (int k = 0; k < 8; k++) begin
      line_present = 1'b0; tick();
      check_val("full_veer_err", err_opn_lp, 12'h340);
      check_val("full_no_ack", clr_cmd_rdy, 0);
      line_present = 1'b1; tick();
      check_val("full_move_busy", busy, 1);
    end
    line_present = 1'b0; tick();
    check_val("full_idle_busy", busy, 0);
    tick();
    check_val("noline_no_ack", clr_cmd_rdy, 0);
    check_val("noline_busy", busy, 0);
    line_present = 1'b1; tick();
    check_val("pend_ack", clr_cmd_rdy, 1);
    check_val("pend_busy", busy, 1);
    cmd_rdy = 1'b0; tick();
    check_val("pend_ack_end", clr_cmd_rdy, 0);
    line_present = 1'b0; tick();
    check_val("pend_veer_left", err_opn_lp, 12'hCC0);
    line_present = 1'b1; tick();
    line_present = 1'b0; tick();
    check_val("pend_end_busy", busy, 0);
    line_present = 1'b1;

    // right veer, right turn, reset mid-turn
    cmd = 16'h000D; cmd_rdy = 1'b1; tick();
    cmd_rdy = 1'b0;
    line_present = 1'b0; tick();
    line_present = 1'b1; tick();
    line_present = 1'b0; tick();
    check_val("rturn_err", err_opn_lp, 12'h1E0);
    check_val("rturn_go", go, 0);
    tick(); tick();
    check_val("rturn_go2", go, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_go", go, 0);
    check_val("mid_rst_err", err_opn_lp, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_clr", clr_cmd_rdy, 0);
    check_val("mid_rst_buzz", buzz, 0);
    check_val("mid_rst_coll", collision, 0);
    tick();
    check_val("mid_rst_busy2", busy, 0);
    #2 rst_n = 1'b1;
    line_present = 1'b1; cmd = 16'h0003; cmd_rdy = 1'b1; tick();
    check_val("post_rst_clr", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    line_present = 1'b0; tick();
    check_val("post_rst_turn_left", err_opn_lp, 12'hE20);
    check_val("post_rst_turn_go", go, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
